poly_eval_ctrl: RTL and testbench

- Sequencer for the floating-point multiply/accumulate `datapath`. It drives one Horner-style polynomial evaluation per accepted request.
- Per term it fetches a coefficient from an external coefficient ROM, pulses the multiply, waits for mul done, pulses the add, and waits for add done.
- It clears the datapath accumulator before each evaluation and captures the final result.
- It returns the result on a valid/ready output handshake and reports errors from a done-wait watchdog.

---
 rtl/poly_eval_pkg.sv | 26 ++
 rtl/poly_eval_watchdog.sv | 41 ++++
 rtl/poly_eval_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_poly_eval_ctrl.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/poly_eval_pkg.sv
// Shared types and default constants for the polynomial evaluation sequencer.
// Holds the FSM state enum and the default parameter values.
package poly_eval_pkg;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_N_COEFF    = 26;
   localparam int DEF_START_IDX  = 16;
   localparam int DEF_CLR_CYCLES = 2;
   localparam int DEF_TIMEOUT    = 255;

   typedef enum logic [3:0] {
      S_IDLE,
      S_CLEAR,
      S_FETCH,
      S_LATCH,
      S_MUL_REQ,
      S_MUL_WAIT,
      S_ADD_REQ,
      S_ADD_WAIT,
      S_STORE,
      S_CAPTURE,
      S_OUT,
      S_ABORT
   } poly_state_e;

endpackage

// File: rtl/poly_eval_watchdog.sv
// Done-wait watchdog: loadable down-counter, expires on its last count.
// Ports: clk_i, rst_i, clr_i (zero), load_i (load TIMEOUT), en_i (count), expire_o.
module poly_eval_watchdog
   import poly_eval_pkg::*;
#(
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic load_i,
   input  logic en_i,
   output logic expire_o
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (load_i)
         cnt_d = CW'(TIMEOUT);
      else if (en_i && cnt_q != '0)
         cnt_d = cnt_q - CW'(1);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   // Loaded with TIMEOUT the cycle before the wait, so a count of 1
   // marks the TIMEOUT-th wait cycle.
   assign expire_o = en_i && (cnt_q == CW'(1));

endmodule

// File: rtl/poly_eval_ctrl.sv
// Horner polynomial sequencer for a multiply/accumulate datapath.
// Ports: start/x request, coeff ROM addr/data, dp_* datapath control, res_* output
// handshake, err_o watchdog flag; cycles_o exists only with POLY_EVAL_PERF_CNT_EN.
module poly_eval_ctrl
   import poly_eval_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int N_COEFF    = DEF_N_COEFF,
   parameter int START_IDX  = DEF_START_IDX,
   parameter int ADDR_W     = $clog2(N_COEFF),
   parameter int CLR_CYCLES = DEF_CLR_CYCLES,
   parameter int TIMEOUT    = DEF_TIMEOUT
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic [DATA_WIDTH-1:0] x_i,
   output logic                  ready_o,
   output logic                  busy_o,
   output logic [ADDR_W-1:0]     coeff_addr_o,
   input  logic [DATA_WIDTH-1:0] coeff_i,
   output logic                  dp_rstn_o,
   output logic [DATA_WIDTH-1:0] dp_signal_o,
   output logic [DATA_WIDTH-1:0] dp_coeff_o,
   output logic                  dp_mul_valid_o,
   output logic                  dp_add_valid_o,
   output logic                  dp_load_result_o,
   input  logic                  dp_mul_done_i,
   input  logic                  dp_add_done_i,
   input  logic [DATA_WIDTH-1:0] dp_result_i,
   output logic                  res_valid_o,
   input  logic                  res_ready_i,
   output logic [DATA_WIDTH-1:0] res_data_o,
   output logic                  err_o
`ifdef POLY_EVAL_PERF_CNT_EN
   ,
   output logic [15:0]           cycles_o
`endif
);

   localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
   localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(START_IDX);
   localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(N_COEFF - 1);
   localparam logic [CLR_W-1:0]  CLR_LAST  = CLR_W'(CLR_CYCLES - 1);

   poly_state_e           state_q, state_d;
   logic [ADDR_W-1:0]     idx_q, idx_d;
   logic [ADDR_W-1:0]     addr_q, addr_d;
   logic [CLR_W-1:0]      clr_cnt_q, clr_cnt_d;
   logic [DATA_WIDTH-1:0] sig_q, sig_d;
   logic [DATA_WIDTH-1:0] coeff_q, coeff_d;
   logic [DATA_WIDTH-1:0] res_q, res_d;
   logic                  err_q, err_d;
   logic                  wd_expire;
`ifdef POLY_EVAL_PERF_CNT_EN
   logic [15:0]           cyc_q, cyc_d;
`endif

   poly_eval_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_wd (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .clr_i    (state_q == S_IDLE),
      .load_i   (state_q == S_MUL_REQ || state_q == S_ADD_REQ),
      .en_i     ((state_q == S_MUL_WAIT && !dp_mul_done_i) ||
                 (state_q == S_ADD_WAIT && !dp_add_done_i)),
      .expire_o (wd_expire)
   );

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      addr_d    = addr_q;
      clr_cnt_d = clr_cnt_q;
      sig_d     = sig_q;
      coeff_d   = coeff_q;
      res_d     = res_q;
      err_d     = err_q;
`ifdef POLY_EVAL_PERF_CNT_EN
      cyc_d = cyc_q;
      if (state_q != S_IDLE && state_q != S_OUT && cyc_q != 16'hFFFF)
         cyc_d = cyc_q + 16'd1;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (start_i) begin
               sig_d     = x_i;
               idx_d     = FIRST_IDX;
               err_d     = 1'b0;
               clr_cnt_d = '0;
               state_d   = S_CLEAR;
`ifdef POLY_EVAL_PERF_CNT_EN
               cyc_d = 16'd1;
`endif
            end
         end
         S_CLEAR, S_ABORT: begin
            if (clr_cnt_q == CLR_LAST) begin
               if (state_q == S_CLEAR) begin
                  addr_d  = idx_q;
                  state_d = S_FETCH;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               clr_cnt_d = clr_cnt_q + CLR_W'(1);
            end
         end
         S_FETCH:   state_d = S_LATCH;
         S_LATCH: begin
            coeff_d = coeff_i;
            state_d = S_MUL_REQ;
         end
         S_MUL_REQ: state_d = S_MUL_WAIT;
         S_MUL_WAIT: begin
            if (dp_mul_done_i) begin
               state_d = S_ADD_REQ;
            end else if (wd_expire) begin
               err_d     = 1'b1;
               clr_cnt_d = '0;
               state_d   = S_ABORT;
            end
         end
         S_ADD_REQ: state_d = S_ADD_WAIT;
         S_ADD_WAIT: begin
            if (dp_add_done_i) begin
               if (idx_q == LAST_IDX) begin
                  state_d = S_STORE;
               end else begin
                  // address is presented on FETCH entry so ROM data lands in LATCH
                  idx_d   = idx_q + ADDR_W'(1);
                  addr_d  = idx_q + ADDR_W'(1);
                  state_d = S_FETCH;
               end
            end else if (wd_expire) begin
               err_d     = 1'b1;
               clr_cnt_d = '0;
               state_d   = S_ABORT;
            end
         end
         S_STORE:   state_d = S_CAPTURE;
         S_CAPTURE: begin
            res_d   = dp_result_i;
            state_d = S_OUT;
         end
         S_OUT: begin
            if (res_ready_i)
               state_d = S_IDLE;
         end
         default:   state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         addr_q    <= '0;
         clr_cnt_q <= '0;
         sig_q     <= '0;
         coeff_q   <= '0;
         res_q     <= '0;
         err_q     <= 1'b0;
`ifdef POLY_EVAL_PERF_CNT_EN
         cyc_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         addr_q    <= addr_d;
         clr_cnt_q <= clr_cnt_d;
         sig_q     <= sig_d;
         coeff_q   <= coeff_d;
         res_q     <= res_d;
         err_q     <= err_d;
`ifdef POLY_EVAL_PERF_CNT_EN
         cyc_q     <= cyc_d;
`endif
      end
   end

   assign ready_o          = (state_q == S_IDLE);
   assign busy_o           = (state_q != S_IDLE);
   assign dp_rstn_o        = !(state_q == S_CLEAR || state_q == S_ABORT);
   assign dp_mul_valid_o   = (state_q == S_MUL_REQ);
   assign dp_add_valid_o   = (state_q == S_ADD_REQ);
   assign dp_load_result_o = (state_q == S_STORE);
   assign res_valid_o      = (state_q == S_OUT);
   assign coeff_addr_o     = addr_q;
   assign dp_signal_o      = sig_q;
   assign dp_coeff_o       = coeff_q;
   assign res_data_o       = res_q;
   assign err_o            = err_q;
`ifdef POLY_EVAL_PERF_CNT_EN
   assign cycles_o         = cyc_q;
`endif

endmodule

// File: tb/tb_poly_eval_ctrl.sv
// Directed bench for poly_eval_ctrl: instance 0 uses START_IDX=16, instance 1 START_IDX=25.
// Datapath model: mul latency 3, add latency 2, 1-cycle coefficient ROM, integer Horner.
module tb_poly_eval_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 rst;
   logic                 hang_mul;
   logic [1:0]           start, res_ready;
   logic [1:0][31:0]     x;
   logic [1:0]           ready, busy, rstn, mulv, addv, loadv, resv, err;
   logic [1:0][4:0]      addr;
   logic [1:0][31:0]     sig, dcoef, rdata;
`ifdef POLY_EVAL_PERF_CNT_EN
   logic [1:0][15:0]     cyc;
`endif

   int checks = 0;
   int errors = 0;

   function automatic logic [31:0] rom_val(int i);
      if (i == 25) return 32'h3F800000;
      return 32'h40000000 + 32'(i) * 32'h00010000;
   endfunction

   function automatic logic [31:0] horner(int s, logic [31:0] xv);
      logic [31:0] acc = 32'h0;
      for (int i = s; i < 26; i++) acc = acc * xv + rom_val(i);
      return acc;
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_dut
      logic [31:0] coeff, prod, acc;
      logic [1:0]  mcnt, acnt;
      logic        mdone, adone;

      always @(posedge clk) begin
         coeff <= rom_val(int'(addr[g]));
         if (rst) begin
            mcnt <= 2'd0;
            acnt <= 2'd0;
         end else begin
            if (mulv[g]) mcnt <= 2'd3;
            else if (mcnt != 2'd0) mcnt <= mcnt - 2'd1;
            if (addv[g]) acnt <= 2'd2;
            else if (acnt != 2'd0) acnt <= acnt - 2'd1;
         end
         if (rst || !rstn[g]) begin
            acc  <= 32'h0;
            prod <= 32'h0;
         end else begin
            if (mulv[g]) prod <= acc * sig[g];
            if (addv[g]) acc <= prod + dcoef[g];
         end
      end

      assign mdone = (mcnt == 2'd1) && !hang_mul;
      assign adone = (acnt == 2'd1);

      poly_eval_ctrl #(
         .START_IDX ((g == 0) ? 16 : 25)
      ) dut (
         .clk_i            (clk),
         .rst_i            (rst),
         .start_i          (start[g]),
         .x_i              (x[g]),
         .ready_o          (ready[g]),
         .busy_o           (busy[g]),
         .coeff_addr_o     (addr[g]),
         .coeff_i          (coeff),
         .dp_rstn_o        (rstn[g]),
         .dp_signal_o      (sig[g]),
         .dp_coeff_o       (dcoef[g]),
         .dp_mul_valid_o   (mulv[g]),
         .dp_add_valid_o   (addv[g]),
         .dp_load_result_o (loadv[g]),
         .dp_mul_done_i    (mdone),
         .dp_add_done_i    (adone),
         .dp_result_i      (acc),
         .res_valid_o      (resv[g]),
         .res_ready_i      (res_ready[g]),
         .res_data_o       (rdata[g]),
         .err_o            (err[g])
`ifdef POLY_EVAL_PERF_CNT_EN
         ,
         .cycles_o         (cyc[g])
`endif
      );
   end

   int mul_n = 0, add_n = 0, load_n = 0, wide_n = 0, vrise_n = 0, rlow1_n = 0;
   logic pm = 1'b0, pa = 1'b0, pl = 1'b0, pv = 1'b0;
   logic [4:0] addr_log [64];

   always @(posedge clk) begin
      if (mulv[0]) begin
         addr_log[mul_n % 64] <= addr[0];
         mul_n <= mul_n + 1;
      end
      if (addv[0]) add_n <= add_n + 1;
      if (loadv[0]) load_n <= load_n + 1;
      if ((mulv[0] && pm) || (addv[0] && pa) || (loadv[0] && pl))
         wide_n <= wide_n + 1;
      if (resv[0] && !pv) vrise_n <= vrise_n + 1;
      if (!rstn[1]) rlow1_n <= rlow1_n + 1;
      pm <= mulv[0];
      pa <= addv[0];
      pl <= loadv[0];
      pv <= resv[0];
   end

   task automatic kick(int g, logic [31:0] xv);
      @(negedge clk);
      start[g] = 1'b1;
      x[g]     = xv;
      @(negedge clk);
      start[g] = 1'b0;
   endtask

   task automatic test_reset;
      rst       = 1'b1;
      hang_mul  = 1'b0;
      start     = '0;
      res_ready = '0;
      x         = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({ready[0], busy[0], rstn[0], mulv[0], addv[0], loadv[0], resv[0], err[0]}
          !== 8'b1010_0000) begin
         errors++;
         $display("FAIL reset_ctrl: got %b expected 10100000",
                  {ready[0], busy[0], rstn[0], mulv[0], addv[0], loadv[0], resv[0], err[0]});
      end
      checks++;
      if ({addr[0], sig[0], dcoef[0], rdata[0]} !== 101'h0) begin
         errors++;
         $display("FAIL reset_data: got %h expected 0", {addr[0], sig[0], dcoef[0], rdata[0]});
      end
   endtask

   task automatic test_default_run;
      int n = 1;
      int bm = mul_n, ba = add_n, bl = load_n, bw = wide_n;
      int bad = 0;
      logic [31:0] held;
      kick(0, 32'hC0A00000);
      while (!resv[0] && n < 600) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n !== 95) begin
         errors++;
         $display("FAIL default_latency: got %0d expected 95", n);
      end
      checks++;
      if (rdata[0] !== horner(16, 32'hC0A00000)) begin
         errors++;
         $display("FAIL default_result: got %h expected %h", rdata[0], horner(16, 32'hC0A00000));
      end
      checks++;
      if ({mul_n - bm, add_n - ba, load_n - bl} !== {32'd10, 32'd10, 32'd1}) begin
         errors++;
         $display("FAIL pulse_counts: got mul %0d add %0d load %0d expected 10 10 1",
                  mul_n - bm, add_n - ba, load_n - bl);
      end
      checks++;
      if (wide_n !== bw) begin
         errors++;
         $display("FAIL pulse_width: got %0d wide pulses expected 0", wide_n - bw);
      end
      for (int k = 0; k < 10; k++)
         if (addr_log[(bm + k) % 64] !== 5'(16 + k)) bad++;
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL addr_sequence: got %0d wrong addresses expected 0", bad);
      end
`ifdef POLY_EVAL_PERF_CNT_EN
      checks++;
      if (cyc[0] !== 16'd95) begin
         errors++;
         $display("FAIL perf_count: got %0d expected 95", cyc[0]);
      end
`endif
      held = rdata[0];
      for (int k = 0; k < 5; k++) begin
         start[0] = (k == 2);
         x[0]     = 32'h12345678;
         @(negedge clk);
         checks++;
         if ({resv[0], rdata[0]} !== {1'b1, held}) begin
            errors++;
            $display("FAIL out_hold: got %b %h expected 1 %h", resv[0], rdata[0], held);
         end
`ifdef POLY_EVAL_PERF_CNT_EN
         checks++;
         if (cyc[0] !== 16'd95) begin
            errors++;
            $display("FAIL perf_frozen: got %0d expected 95", cyc[0]);
         end
`endif
      end
      start[0]     = 1'b0;
      res_ready[0] = 1'b1;
      @(negedge clk);
      res_ready[0] = 1'b0;
      checks++;
      if ({ready[0], resv[0]} !== 2'b10) begin
         errors++;
         $display("FAIL ready_after_hs: got %b expected 10", {ready[0], resv[0]});
      end
      repeat (3) @(negedge clk);
      checks++;
      if ({busy[0], sig[0]} !== {1'b0, 32'hC0A00000}) begin
         errors++;
         $display("FAIL start_in_out_ignored: got %b %h expected 0 c0a00000", busy[0], sig[0]);
      end
   endtask

   task automatic test_one_term;
      int n = 1;
      int br = rlow1_n;
      kick(1, 32'h3F800000);
      while (!resv[1] && n < 200) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n !== 14) begin
         errors++;
         $display("FAIL one_term_latency: got %0d expected 14", n);
      end
      checks++;
      if (rdata[1] !== 32'h3F800000) begin
         errors++;
         $display("FAIL one_term_result: got %h expected 3f800000", rdata[1]);
      end
      checks++;
      if (rlow1_n - br !== 2) begin
         errors++;
         $display("FAIL clear_width: got %0d expected 2", rlow1_n - br);
      end
      res_ready[1] = 1'b1;
      @(negedge clk);
      res_ready[1] = 1'b0;
   endtask

   task automatic test_timeout;
      int n = 1;
      int bv = vrise_n;
      hang_mul = 1'b1;
      kick(0, 32'h40000000);
`ifdef POLY_EVAL_PERF_CNT_EN
      checks++;
      if (cyc[0] !== 16'd1) begin
         errors++;
         $display("FAIL perf_cleared: got %0d expected 1", cyc[0]);
      end
`endif
      while (!err[0] && n < 600) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n !== 261) begin
         errors++;
         $display("FAIL timeout_time: got %0d expected 261", n);
      end
      checks++;
      if ({rstn[0], busy[0]} !== 2'b01) begin
         errors++;
         $display("FAIL abort_clear0: got %b expected 01", {rstn[0], busy[0]});
      end
      @(negedge clk);
      checks++;
      if (rstn[0] !== 1'b0) begin
         errors++;
         $display("FAIL abort_clear1: got %b expected 0", rstn[0]);
      end
      @(negedge clk);
      checks++;
      if ({ready[0], rstn[0], err[0]} !== 3'b111) begin
         errors++;
         $display("FAIL abort_idle: got %b expected 111", {ready[0], rstn[0], err[0]});
      end
      repeat (3) @(negedge clk);
      checks++;
      if (vrise_n !== bv) begin
         errors++;
         $display("FAIL abort_no_result: got %0d results expected 0", vrise_n - bv);
      end
      hang_mul = 1'b0;
      kick(0, 32'h40000000);
      checks++;
      if (err[0] !== 1'b0) begin
         errors++;
         $display("FAIL err_cleared: got %b expected 0", err[0]);
      end
      n = 0;
      while (!resv[0] && n < 600) begin
         @(negedge clk);
         n++;
      end
      res_ready[0] = 1'b1;
      @(negedge clk);
      res_ready[0] = 1'b0;
   endtask

   task automatic test_reset_midop;
      int n = 0;
      int ba = add_n;
      int bm;
      kick(0, 32'h3F000000);
      while (add_n - ba < 4 && n < 600) begin
         @(negedge clk);
         n++;
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({ready[0], busy[0], rstn[0], mulv[0], addv[0], loadv[0], resv[0], err[0]}
          !== 8'b1010_0000) begin
         errors++;
         $display("FAIL midop_reset_ctrl: got %b expected 10100000",
                  {ready[0], busy[0], rstn[0], mulv[0], addv[0], loadv[0], resv[0], err[0]});
      end
      checks++;
      if ({addr[0], sig[0], dcoef[0], rdata[0]} !== 101'h0) begin
         errors++;
         $display("FAIL midop_reset_data: got %h expected 0", {addr[0], sig[0], dcoef[0], rdata[0]});
      end
      bm = mul_n;
      n  = 1;
      kick(0, 32'h00000003);
      while (!resv[0] && n < 600) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if ({n, mul_n - bm} !== {32'd95, 32'd10}) begin
         errors++;
         $display("FAIL rerun_timing: got %0d cycles %0d muls expected 95 10", n, mul_n - bm);
      end
      checks++;
      if (rdata[0] !== horner(16, 32'h00000003)) begin
         errors++;
         $display("FAIL rerun_result: got %h expected %h", rdata[0], horner(16, 32'h00000003));
      end
      res_ready[0] = 1'b1;
      @(negedge clk);
      res_ready[0] = 1'b0;
   endtask

   initial begin
      test_reset();
      test_default_run();
      test_one_term();
      test_timeout();
      test_reset_midop();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
